// File: rtl/streebog_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : streebog_round_sequencer
// Purpose  : Sequences the 12 LPSX rounds and key schedule of Streebog E(K,m),
//            sharing one external LPS core and driving the C-constant ROM.
//            Optional abort/drain support under macro STREEBOG_SEQ_ABORT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module streebog_round_sequencer #(
   parameter int ROUNDS = 12
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [511:0] key_in,
   input  logic [511:0] msg_in,
`ifdef STREEBOG_SEQ_ABORT_EN
   input  logic         abort,
`endif
   output logic         ready,
   output logic         valid,
   output logic [511:0] result,
   output logic         rom_ena,
   output logic [3:0]   rom_din,
   input  logic [511:0] rom_dout,
   output logic         lps_start,
   output logic [511:0] lps_din,
   input  logic [511:0] lps_dout,
   input  logic         lps_ready
);

   localparam logic [2:0] c_IDLE   = 3'd0;
   localparam logic [2:0] c_RND_S  = 3'd1;
   localparam logic [2:0] c_WAIT_S = 3'd2;
   localparam logic [2:0] c_RND_K  = 3'd3;
   localparam logic [2:0] c_WAIT_K = 3'd4;
   localparam logic [2:0] c_FIN    = 3'd5;
`ifdef STREEBOG_SEQ_ABORT_EN
   localparam logic [2:0] c_DRAIN  = 3'd6;
`endif
   localparam logic [3:0] c_LAST_ROUND = 4'(ROUNDS - 1);

   logic [2:0]   r_state;
   logic [2:0]   w_state_nxt;
   logic [511:0] r_st;
   logic [511:0] r_key;
   logic [511:0] r_result;
   logic [511:0] r_lps_din;
   logic [511:0] w_lps_din;
   logic [3:0]   r_round;
   logic         r_valid;
   logic         w_abort;
   logic         w_last;

`ifdef STREEBOG_SEQ_ABORT_EN
   assign w_abort = abort;
`else
   assign w_abort = 1'b0;
`endif

   assign w_last = (r_round == c_LAST_ROUND);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_IDLE:   if (start) w_state_nxt = c_RND_S;
         c_RND_S:  w_state_nxt = w_abort ? c_IDLE : c_WAIT_S;
         c_WAIT_S: begin
            // An abort coinciding with the response leaves nothing to drain.
            if (w_abort) begin
`ifdef STREEBOG_SEQ_ABORT_EN
               w_state_nxt = lps_ready ? c_IDLE : c_DRAIN;
`else
               w_state_nxt = c_IDLE;
`endif
            end else if (lps_ready) begin
               w_state_nxt = c_RND_K;
            end
         end
         c_RND_K:  w_state_nxt = w_abort ? c_IDLE : c_WAIT_K;
         c_WAIT_K: begin
            if (w_abort) begin
`ifdef STREEBOG_SEQ_ABORT_EN
               w_state_nxt = lps_ready ? c_IDLE : c_DRAIN;
`else
               w_state_nxt = c_IDLE;
`endif
            end else if (lps_ready) begin
               w_state_nxt = w_last ? c_FIN : c_RND_S;
            end
         end
         c_FIN:    w_state_nxt = c_IDLE;
`ifdef STREEBOG_SEQ_ABORT_EN
         c_DRAIN:  if (lps_ready) w_state_nxt = c_IDLE;
`endif
         default:  w_state_nxt = c_IDLE;
      endcase
   end

   // Requests are suppressed on abort so no orphan LPS job is left in flight.
   always_comb begin
      ready     = (r_state == c_IDLE);
      rom_ena   = 1'b0;
      lps_start = 1'b0;
      w_lps_din = r_lps_din;
      case (r_state)
         c_RND_S: begin
            if (!w_abort) begin
               rom_ena   = 1'b1;
               lps_start = 1'b1;
               w_lps_din = r_st ^ r_key;
            end
         end
         c_RND_K: begin
            if (!w_abort) begin
               lps_start = 1'b1;
               w_lps_din = r_key ^ rom_dout;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_st      <= '0;
         r_key     <= '0;
         r_round   <= '0;
         r_result  <= '0;
         r_valid   <= 1'b0;
         r_lps_din <= '0;
      end else begin
         r_valid   <= 1'b0;
         r_lps_din <= w_lps_din;
         case (r_state)
            c_IDLE: begin
               if (start) begin
                  r_st    <= msg_in;
                  r_key   <= key_in;
                  r_round <= '0;
               end
            end
            c_WAIT_S: begin
               if (lps_ready && !w_abort) r_st <= lps_dout;
            end
            c_WAIT_K: begin
               if (lps_ready && !w_abort) begin
                  r_key <= lps_dout;
                  if (!w_last) r_round <= r_round + 4'd1;
               end
            end
            c_FIN: begin
               r_result <= r_st ^ r_key;
               r_valid  <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign lps_din = w_lps_din;
   assign rom_din = r_round;
   assign valid   = r_valid;
   assign result  = r_result;

endmodule
`default_nettype wire

// File: tb/tb_streebog_round_sequencer.sv
`default_nettype none
// Self-checking bench for streebog_round_sequencer: LPS stub with programmable
// latency, registered C-ROM stand-in and a round-level reference model.
module tb_streebog_round_sequencer;
   localparam int ROUNDS = 12;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [511:0] key_in, msg_in, result, rom_dout, lps_din, lps_dout;
   logic         ready, valid, rom_ena, lps_start, lps_ready;
   logic [3:0]   rom_din;
`ifdef STREEBOG_SEQ_ABORT_EN
   logic         abort;
`endif

   streebog_round_sequencer #(.ROUNDS(ROUNDS)) dut (
      .clk(clk), .rst(rst), .start(start), .key_in(key_in), .msg_in(msg_in),
`ifdef STREEBOG_SEQ_ABORT_EN
      .abort(abort),
`endif
      .ready(ready), .valid(valid), .result(result),
      .rom_ena(rom_ena), .rom_din(rom_din), .rom_dout(rom_dout),
      .lps_start(lps_start), .lps_din(lps_din), .lps_dout(lps_dout),
      .lps_ready(lps_ready)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit lps_ident = 1'b1;
   int lat_mode  = 1;   // 0: random 1..8 per request, else fixed latency
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [511:0] crom [0:15];
   logic [511:0] rom_q;
   always @(posedge clk) if (rom_ena) rom_q <= crom[rom_din];
   assign rom_dout = rom_q;

   function automatic logic [511:0] rand512();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [511:0] lps_f(input logic [511:0] x);
      if (lps_ident) return x;
      return ({x[510:0], x[511]} ^ {x[255:0], x[511:256]}) + {16{32'h9e3779b9}};
   endfunction

   // E(K,m): 12 rounds of s=LPS(s^K_i), K_(i+1)=LPS(K_i^C_i), then s^K13.
   function automatic logic [511:0] model(input logic [511:0] k, input logic [511:0] m);
      logic [511:0] s, kk;
      s = m; kk = k;
      for (int i = 0; i < ROUNDS; i++) begin
         s  = lps_f(s ^ kk);
         kk = lps_f(kk ^ crom[i]);
      end
      return s ^ kk;
   endfunction

   // LPS core stub
   initial begin : lps_stub
      logic [511:0] d;
      int l;
      lps_ready = 1'b0;
      lps_dout  = '0;
      forever begin
         @(negedge clk);
         if (lps_start === 1'b1 && rst !== 1'b1) begin
            d = lps_din;
            l = (lat_mode == 0) ? int'($urandom_range(1, 8)) : lat_mode;
            repeat (l) @(posedge clk);
            #1 lps_ready = 1'b1;
            lps_dout = lps_f(d);
            @(posedge clk);
            #1 lps_ready = 1'b0;
         end
      end
   end

   int n_lps = 0, n_rom = 0, n_valid = 0, last_rdy_cyc = -1, max_rom_din = 0;
   logic [3:0] rom_log [0:1023];
   always @(negedge clk) begin
      if (rst !== 1'b1) begin
         if (lps_start) n_lps <= n_lps + 1;
         if (rom_ena) begin
            rom_log[n_rom[9:0]] <= rom_din;
            n_rom <= n_rom + 1;
            if (int'(rom_din) > max_rom_din) max_rom_din <= int'(rom_din);
         end
         if (valid) n_valid <= n_valid + 1;
         if (lps_ready) last_rdy_cyc <= cyc;
      end
   end

   task automatic run_op(input logic [511:0] k, input logic [511:0] m, input bit hold,
                         output logic [511:0] res, output int lat, output int pulses,
                         output bit seq_ok);
      int n, lp0, rm0, roms;
      n = 0;
      while (ready !== 1'b1 && n < 300) begin @(posedge clk); #1; n++; end
      key_in = k; msg_in = m; start = 1'b1;
      @(posedge clk); #1;
      lp0 = n_lps; rm0 = n_rom;
      checks++;
      if (ready !== 1'b0) begin errors++; $display("FAIL accept: ready=%b required 0", ready); end
      if (!hold) start = 1'b0;
      n = 0;
      while (n < 3000) begin
         if (hold) begin key_in = rand512(); msg_in = rand512(); end
         @(posedge clk); #1;
         n++;
         if (valid === 1'b1) break;
      end
      checks++;
      if (valid !== 1'b1) begin errors++; $display("FAIL valid_timeout: valid=%b after %0d cycles required 1", valid, n); end
      lat = n; res = result; pulses = n_lps - lp0; roms = n_rom - rm0;
      seq_ok = (roms == ROUNDS);
      for (int i = 0; i < roms && i < 16; i++)
         if (int'(rom_log[(rm0 + i) % 1024]) != i) seq_ok = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; key_in = rand512(); msg_in = rand512();
      repeat (2) @(posedge clk); #1;
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b required 1", ready); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b required 0", valid); end
      checks++; if (result !== '0) begin errors++; $display("FAIL rst_result: got %h required 0", result); end
      checks++; if (rom_ena !== 1'b0 || rom_din !== 4'd0) begin errors++; $display("FAIL rst_rom: ena=%b din=%0d required 0/0", rom_ena, rom_din); end
      checks++; if (lps_start !== 1'b0 || lps_din !== '0) begin errors++; $display("FAIL rst_lps: start=%b din=%h required 0/0", lps_start, lps_din); end
      rst = 1'b0; start = 1'b0;
      @(posedge clk); #1;
      checks++; if (ready !== 1'b1 || lps_start !== 1'b0) begin errors++; $display("FAIL rst_start_ignored: ready=%b lps_start=%b required 1/0", ready, lps_start); end
   endtask

   task automatic test_identity();
      logic [511:0] res, exp;
      int lat, pl;
      bit sq;
      lps_ident = 1'b1; lat_mode = 1;
      exp = model('0, '0);
      run_op('0, '0, 1'b0, res, lat, pl, sq);
      checks++; if (res !== exp) begin errors++; $display("FAIL ident_result: got %h required %h", res, exp); end
      checks++; if (lat != 49) begin errors++; $display("FAIL ident_latency: got %0d required 49", lat); end
      checks++; if (pl != 2*ROUNDS) begin errors++; $display("FAIL ident_lps_pulses: got %0d required %0d", pl, 2*ROUNDS); end
      checks++; if (!sq) begin errors++; $display("FAIL ident_rom_seq: got %b required 1", sq); end
      @(posedge clk); #1;
      checks++; if (valid !== 1'b0 || result !== res) begin errors++; $display("FAIL ident_valid_pulse: valid=%b required 0, result held=%b", valid, result === res); end
   endtask

   task automatic test_latency();
      logic [511:0] res, exp, k, m;
      int lat, pl;
      bit sq;
      lps_ident = 1'b1; lat_mode = 5;
      exp = model('0, '0);
      run_op('0, '0, 1'b0, res, lat, pl, sq);
      checks++; if (res !== exp) begin errors++; $display("FAIL lat5_result: got %h required %h", res, exp); end
      checks++; if (lat != 145) begin errors++; $display("FAIL lat5_latency: got %0d required 145", lat); end
      checks++; if (pl != 2*ROUNDS) begin errors++; $display("FAIL lat5_lps_pulses: got %0d required %0d", pl, 2*ROUNDS); end
      lat_mode = 0;
      run_op('0, '0, 1'b0, res, lat, pl, sq);
      checks++; if (res !== exp) begin errors++; $display("FAIL latrnd_result: got %h required %h", res, exp); end
      checks++; if (pl != 2*ROUNDS || !sq) begin errors++; $display("FAIL latrnd_pulses: got %0d seq=%b required %0d seq=1", pl, sq, 2*ROUNDS); end
      lps_ident = 1'b0;
      for (int i = 0; i < 3; i++) begin
         k = rand512(); m = rand512(); exp = model(k, m);
         run_op(k, m, 1'b0, res, lat, pl, sq);
         checks++; if (res !== exp) begin errors++; $display("FAIL rand_result[%0d]: got %h required %h", i, res, exp); end
      end
      checks++; if (max_rom_din > ROUNDS - 1) begin errors++; $display("FAIL rom_index_range: got %0d required <=%0d", max_rom_din, ROUNDS - 1); end
   endtask

   task automatic test_back_to_back();
      logic [511:0] res, exp, k, m;
      int lat, pl;
      bit sq;
      lps_ident = 1'b0; lat_mode = 2;
      for (int i = 0; i < 3; i++) begin
         k = rand512(); m = rand512(); exp = model(k, m);
         run_op(k, m, 1'b1, res, lat, pl, sq);
         checks++; if (res !== exp) begin errors++; $display("FAIL b2b_result[%0d]: got %h required %h", i, res, exp); end
         checks++; if (lat != 2*ROUNDS*3 + 1) begin errors++; $display("FAIL b2b_latency[%0d]: got %0d required %0d", i, lat, 2*ROUNDS*3 + 1); end
      end
      start = 1'b0;
      @(posedge clk); #1;
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b_idle: ready=%b required 1", ready); end
   endtask

   task automatic test_reset_mid();
      logic [511:0] res, exp;
      int lat, pl, cnt, n, nv0;
      bit sq;
      lps_ident = 1'b0; lat_mode = 2;
      n = 0;
      while (ready !== 1'b1 && n < 300) begin @(posedge clk); #1; n++; end
      key_in = rand512(); msg_in = rand512(); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cnt = 0; n = 0;
      while (n < 500) begin
         if (lps_start === 1'b1) cnt++;
         if (cnt == 12) break;
         @(posedge clk); #1; n++;
      end
      checks++; if (rom_din !== 4'd5) begin errors++; $display("FAIL mid_round: rom_din=%0d required 5", rom_din); end
      @(posedge clk); #1;
      nv0 = n_valid;
      rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (ready !== 1'b1 || valid !== 1'b0 || result !== '0 || rom_ena !== 1'b0 ||
          rom_din !== 4'd0 || lps_start !== 1'b0 || lps_din !== '0) begin
         errors++;
         $display("FAIL mid_rst_outputs: ready=%b valid=%b result0=%b rom_ena=%b rom_din=%0d lps_start=%b lps_din0=%b required 1/0/1/0/0/0/1",
                  ready, valid, result === '0, rom_ena, rom_din, lps_start, lps_din === '0);
      end
      repeat (10) @(posedge clk); #1;
      rst = 1'b0;
      checks++; if (n_valid != nv0) begin errors++; $display("FAIL mid_rst_no_valid: got %0d pulses required 0", n_valid - nv0); end
      lps_ident = 1'b1; lat_mode = 1;
      exp = model('0, '0);
      run_op('0, '0, 1'b0, res, lat, pl, sq);
      checks++; if (res !== exp) begin errors++; $display("FAIL mid_rst_rerun: got %h required %h", res, exp); end
   endtask

`ifdef STREEBOG_SEQ_ABORT_EN
   task automatic test_abort();
      logic [511:0] res, exp, k, m;
      int lat, pl, n, lp0, nv0;
      bit sq;
      lps_ident = 1'b0; lat_mode = 6;
      n = 0;
      while (ready !== 1'b1 && n < 300) begin @(posedge clk); #1; n++; end
      key_in = rand512(); msg_in = rand512(); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lp0 = n_lps; nv0 = n_valid;
      @(posedge clk); #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      n = 0;
      while (ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL abort_ready_timeout: ready=%b required 1", ready); end
      checks++; if (cyc != last_rdy_cyc + 1) begin errors++; $display("FAIL abort_ready_timing: cycle %0d required %0d", cyc, last_rdy_cyc + 1); end
      checks++; if (n_lps - lp0 != 1) begin errors++; $display("FAIL abort_lps_pulses: got %0d required 1", n_lps - lp0); end
      checks++; if (n_valid != nv0) begin errors++; $display("FAIL abort_no_valid: got %0d required 0", n_valid - nv0); end
      k = rand512(); m = rand512(); exp = model(k, m);
      run_op(k, m, 1'b0, res, lat, pl, sq);
      checks++; if (res !== exp) begin errors++; $display("FAIL abort_next_op: got %h required %h", res, exp); end
   endtask
`endif

   initial begin
      rst = 1'b1; start = 1'b0; key_in = '0; msg_in = '0;
`ifdef STREEBOG_SEQ_ABORT_EN
      abort = 1'b0;
`endif
      for (int i = 0; i < 16; i++) crom[i] = rand512();
      test_reset();
      test_identity();
      test_latency();
      test_back_to_back();
      test_reset_mid();
`ifdef STREEBOG_SEQ_ABORT_EN
      test_abort();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/streebog_round_sequencer.md
Name: streebog_round_sequencer

Overview:
- Control and datapath stage for the Streebog E(K,m) transform, placed directly downstream of the C round-constant ROM.
- Drives the ROM index (0..11) and consumes its 512-bit constant output.
- Shares one external LPS core between the message-state path and the key-schedule path through a start/ready handshake.
- Produces E(K,m) = X[K13]·LPSX[K12]·…·LPSX[K1](m), with K1 = K and K(i+1) = LPS(K(i) xor C(i)).

Parameters:
ROUNDS, 12, number of LPSX rounds; also the number of ROM constants consumed (indices 0..ROUNDS-1).

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
start  in  1  begin operation; sampled only while ready=1
key_in  in  512  K, latched on accepted start
msg_in  in  512  m, latched on accepted start
ready  out  1  idle and able to accept start
valid  out  1  one-cycle pulse; result holds a new value
result  out  512  E(K,m); held until the next valid
rom_ena  out  1  C-ROM read enable
rom_din  out  4  C-ROM index
rom_dout  in  512  C-ROM data; registered, valid 1 cycle after rom_ena, held while rom_ena=0
lps_start  out  1  one-cycle LPS request
lps_din  out  512  LPS operand; held until the next request
lps_dout  in  512  LPS result, sampled when lps_ready=1
lps_ready  in  1  LPS done; arrives L>=1 cycles after lps_start

Behaviour:
- Clocking and reset: one clock (clk); synchronous active-high reset (rst).
- Reset values: ready=1, valid=0, result=0, rom_ena=0, rom_din=0, lps_start=0, lps_din=0, round=0, state=IDLE.
- rst overrides everything. Reset mid-operation discards all partial state; no valid is produced.
- Internal registers: st (512), key (512), round (4).
- IDLE: start=1 latches st<=msg_in, key<=key_in, round<=0, ready<=0, then goes to RND_S.
- RND_S (1 cycle):
  - lps_start=1, lps_din=st xor key.
  - rom_ena=1, rom_din=round.
  - Next state WAIT_S.
- WAIT_S: on lps_ready, st<=lps_dout and go to RND_K.
- RND_K (1 cycle): lps_start=1, lps_din=key xor rom_dout, then go to WAIT_K. rom_dout is already stable at this point: at least 2 cycles after rom_ena.
- WAIT_K: on lps_ready, key<=lps_dout.
  - If round==ROUNDS-1, go to FIN.
  - Otherwise round<=round+1 and go to RND_S.
- FIN: result<=st xor key, valid<=1 for exactly one cycle, ready<=1, then IDLE.
- Signal rules:
  - lps_ready is ignored outside WAIT_S and WAIT_K.
  - start is ignored while ready=0.
  - rom_ena is asserted only in RND_S, exactly ROUNDS times per operation.
- Latency: for a constant LPS latency L, valid rises 2·ROUNDS·(L+1)+1 edges after the edge that samples start. This is 49 edges for L=1.
- Back-to-back operation: start may be accepted on the edge after valid, because ready is already 1 in the valid cycle.
- rom_din never exceeds ROUNDS-1, so the ROM's undefined indices 12..15 are never addressed.

Optional Feature:
STREEBOG_SEQ_ABORT_EN
- Defined:
  - Adds input abort (1 bit).
  - abort=1 in RND_S or RND_K: go to IDLE next edge.
  - abort=1 in WAIT_S or WAIT_K: go to DRAIN, which waits for the outstanding lps_ready, discards it, then goes to IDLE.
  - Abort never produces valid. ready stays 0 until IDLE.
  - abort is ignored in IDLE and FIN.
- Not defined: no abort port, no DRAIN state; behaviour is identical to abort tied 0.

Test Plan:
1. Reset: assert rst 2 cycles -> ready=1, valid=0, result=0, rom_ena=0, lps_start=0; start during rst is ignored.
2. Identity LPS stub (lps_dout=lps_din, L=1), real C ROM attached, K=0, m=0 -> rom_din sequence 0,1,…,11; 24 lps_start pulses; valid at edge 49; result equals the bench model XOR of K1..K13, where K(i+1)=K(i) xor C(i).
3. Same vectors with L=5, then with a random per-request latency 1..8 -> identical result; for L=5, valid at edge 145; no extra lps_start pulses.
4. start held high continuously across 3 operations with different K/m -> start re-accepted on the edge after each valid; start pulses in mid-operation cycles do not alter st or key.
5. rst pulsed during round 5 in WAIT_K -> all outputs return to reset values on the next edge; a fresh operation then matches the scenario 2 result.
6. With STREEBOG_SEQ_ABORT_EN: abort in WAIT_S with L=6 -> no lps_start issued until the pending lps_ready; ready rises 1 cycle after it; no valid; the next operation is correct.
